// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI write controller: FSM states, frame layout,
// tick counter width and the peripheral register map.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam int TICK_BITS  = 8;

  localparam logic WRITE_BIT = 1'b1;

  localparam logic [ADDR_BITS-1:0] REG_MAX_ADDR = 7'h04;

  localparam logic [ADDR_BITS-1:0] REG_OUT_7_0  = 7'h00;
  localparam logic [ADDR_BITS-1:0] REG_OUT_15_8 = 7'h01;
  localparam logic [ADDR_BITS-1:0] REG_PWM_7_0  = 7'h02;
  localparam logic [ADDR_BITS-1:0] REG_PWM_15_8 = 7'h03;
  localparam logic [ADDR_BITS-1:0] REG_DUTY     = 7'h04;

  // A write frame is the write flag followed by address and data, MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] data
  );
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_write_controller_if.sv
// Command handshake plus SPI pins and status of the SPI write controller.
// The controller side uses the slave modport, the command source the master.
interface spi_write_controller_if;
  import spi_ctrl_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_data;
  logic                 sclk;
  logic                 copi;
  logic                 ncs;
  logic                 busy;
  logic                 done;
  logic                 cmd_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, sclk, copi, ncs, busy, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, sclk, copi, ncs, busy, done, cmd_err
  );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: tick is high for one cycle every CLK_DIV cycles.
// The counter wraps on every tick, which is exactly when the controller
// changes state, and is held at zero while restart is high (IDLE).
module spi_half_tick
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  logic [TICK_BITS-1:0] cnt;

  assign tick = (cnt == TICK_BITS'(CLK_DIV - 1));

  // Count system clocks within the current half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_write_controller.sv
// SPI mode-0 write controller: latches {write, addr, data} on accept and
// shifts it out MSB first, then holds chip select high for a guard gap.
// Optional macro SPI_CTRL_ADDR_CHECK_EN: commands addressing beyond the
// register map are accepted but dropped with a one-cycle cmd_err pulse.
module spi_write_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  spi_write_controller_if.slave bus
);

  state_t                  state;
  logic [FRAME_BITS-2:0]   shift;
  logic [3:0]              bits_left;
  logic                    gap_half;
  logic                    sclk_q;
  logic                    copi_q;
  logic                    ncs_q;
  logic                    done_q;
  logic                    tick;
  logic [FRAME_BITS-1:0]   frame_in;
`ifdef SPI_CTRL_ADDR_CHECK_EN
  logic                    err_q;
`endif

  assign frame_in = build_frame(bus.cmd_addr, bus.cmd_data);

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // Frame sequencer: every pin and pulse output is a flop set here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bits_left <= 4'd0;
      gap_half  <= 1'b0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      done_q    <= 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
`ifdef SPI_CTRL_ADDR_CHECK_EN
            if (bus.cmd_addr > REG_MAX_ADDR) begin
              err_q <= 1'b1;
            end else begin
`endif
              state     <= LEAD;
              ncs_q     <= 1'b0;
              sclk_q    <= 1'b0;
              copi_q    <= frame_in[FRAME_BITS-1];
              shift     <= frame_in[FRAME_BITS-2:0];
              bits_left <= 4'd15;
`ifdef SPI_CTRL_ADDR_CHECK_EN
            end
`endif
          end
        end
        LEAD: begin
          if (tick) begin
            state  <= HIGH;
            sclk_q <= 1'b1;
          end
        end
        HIGH: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (bits_left != 4'd0) begin
              state     <= LOW;
              copi_q    <= shift[FRAME_BITS-2];
              shift     <= {shift[FRAME_BITS-3:0], 1'b0};
              bits_left <= bits_left - 4'd1;
            end else begin
              state <= TRAIL;
            end
          end
        end
        LOW: begin
          if (tick) begin
            state  <= HIGH;
            sclk_q <= 1'b1;
          end
        end
        TRAIL: begin
          if (tick) begin
            state    <= GAP;
            ncs_q    <= 1'b1;
            copi_q   <= 1'b0;
            done_q   <= 1'b1;
            gap_half <= 1'b0;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_half) begin
              state    <= IDLE;
              gap_half <= 1'b0;
            end else begin
              gap_half <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          ncs_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.sclk      = sclk_q;
  assign bus.copi      = copi_q;
  assign bus.ncs       = ncs_q;
  assign bus.done      = done_q;
`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign bus.cmd_err   = err_q;
`else
  assign bus.cmd_err   = 1'b0;
`endif

endmodule
